// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_arbiter
// Desc     : Round-robin snooping-bus controller for a 4-core MESI cluster.
//            Optional memory-ack timeout enabled by defining ARB_MEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module snoop_bus_arbiter #(
   parameter int NUM_PROC    = 4,
   parameter int ID_W        = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PROC-1:0]        req,
   input  logic [NUM_PROC-1:0]        req_rdwr,
   input  logic [NUM_PROC*ADDR_W-1:0] req_addr,
   input  logic [NUM_PROC-1:0]        wrbk,
   input  logic [NUM_PROC*DATA_W-1:0] wrbk_data,
   input  logic [NUM_PROC-1:0]        shared_in,
   input  logic [DATA_W-1:0]          mem_rdata,
   input  logic                       mem_ack,
   output logic [NUM_PROC-1:0]        grant,
   output logic                       bus_valid,
   output logic [ID_W-1:0]            bus_proc_id,
   output logic [ADDR_W-1:0]          bus_addr,
   output logic                       bus_rdwr,
   output logic                       shared,
   output logic                       ready_to_read,
   output logic [DATA_W-1:0]          fill_data,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       done,
   output logic                       err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SNOOP = 3'd1;
   localparam logic [2:0] S_WB    = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_FILL  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]          state_q,   state_d;
   logic [ID_W-1:0]     rr_ptr_q,  rr_ptr_d;
   logic [NUM_PROC-1:0] grant_q,   grant_d;
   logic [ID_W-1:0]     owner_q,   owner_d;
   logic [ADDR_W-1:0]   addr_q,    addr_d;
   logic                rdwr_q,    rdwr_d;
   logic                shared_q,  shared_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic [DATA_W-1:0]   fill_q,    fill_d;

   logic [ADDR_W-1:0]   addr_arr_w [NUM_PROC];
   logic [DATA_W-1:0]   wbk_arr_w  [NUM_PROC];
   logic [ID_W:0]       arb_sum_w;
   logic [ID_W-1:0]     arb_idx_w;
   logic                arb_found_w;
   logic [NUM_PROC-1:0] wb_hits_w;
   logic [ID_W-1:0]     wb_idx_w;
   logic                mem_phase_w;
   logic                timeout_w;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PROC; gi++) begin : g_unpack
         assign addr_arr_w[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign wbk_arr_w[gi]  = wrbk_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      arb_found_w = 1'b0;
      arb_idx_w   = '0;
      arb_sum_w   = '0;
      for (int off = 0; off < NUM_PROC; off++) begin
         arb_sum_w = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
         if (arb_sum_w >= (ID_W+1)'(NUM_PROC))
            arb_sum_w = arb_sum_w - (ID_W+1)'(NUM_PROC);
         if (!arb_found_w && req[arb_sum_w[ID_W-1:0]]) begin
            arb_found_w = 1'b1;
            arb_idx_w   = arb_sum_w[ID_W-1:0];
         end
      end
   end

   // Lowest-index non-owner write-back wins; descending scan lets it overwrite last.
   assign wb_hits_w = wrbk & ~grant_q;
   always_comb begin
      wb_idx_w = '0;
      for (int i = NUM_PROC-1; i >= 0; i--) begin
         if (wb_hits_w[i])
            wb_idx_w = ID_W'(i);
      end
   end

   assign mem_phase_w = (state_q == S_WB) || (state_q == S_MEM);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      rdwr_d    = rdwr_q;
      shared_d  = shared_q;
      wb_data_d = wb_data_q;
      fill_d    = fill_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found_w) begin
               grant_d            = '0;
               grant_d[arb_idx_w] = 1'b1;
               owner_d            = arb_idx_w;
               addr_d             = addr_arr_w[arb_idx_w];
               rdwr_d             = req_rdwr[arb_idx_w];
               state_d            = S_SNOOP;
            end
         end
         S_SNOOP: begin
            shared_d = |(shared_in & ~grant_q);
            if (|wb_hits_w) begin
               wb_data_d = wbk_arr_w[wb_idx_w];
               state_d   = S_WB;
            end else begin
               state_d = rdwr_q ? S_MEM : S_DONE;
            end
         end
         S_WB: begin
            if (mem_ack) begin
               state_d = rdwr_q ? S_MEM : S_DONE;
            end else if (timeout_w) begin
               fill_d  = '0;
               state_d = S_DONE;
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               fill_d  = mem_rdata;
               state_d = S_FILL;
            end else if (timeout_w) begin
               fill_d  = '0;
               state_d = S_DONE;
            end
         end
         S_FILL: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            grant_d  = '0;
            rr_ptr_d = (owner_q == ID_W'(NUM_PROC-1)) ? '0 : owner_q + 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         owner_q   <= '0;
         addr_q    <= '0;
         rdwr_q    <= 1'b0;
         shared_q  <= 1'b0;
         wb_data_q <= '0;
         fill_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         rdwr_q    <= rdwr_d;
         shared_q  <= shared_d;
         wb_data_q <= wb_data_d;
         fill_q    <= fill_d;
      end
   end

`ifdef ARB_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   logic [CNT_W-1:0] to_cnt_q;

   // Counts cycles spent in the current WB or MEM visit; any state change restarts it.
   always_ff @(posedge clk) begin
      if (rst)
         to_cnt_q <= '0;
      else if ((state_d != state_q) || !mem_phase_w)
         to_cnt_q <= '0;
      else
         to_cnt_q <= to_cnt_q + 1'b1;
   end

   assign timeout_w = mem_phase_w && !mem_ack && (to_cnt_q == CNT_W'(MEM_TIMEOUT));
`else
   assign timeout_w = 1'b0;
`endif

   assign err           = timeout_w;
   assign grant         = grant_q;
   assign bus_valid     = (state_q == S_SNOOP);
   assign bus_proc_id   = owner_q;
   assign bus_addr      = addr_q;
   assign bus_rdwr      = rdwr_q;
   assign shared        = shared_q;
   assign ready_to_read = (state_q == S_FILL);
   assign fill_data     = fill_q;
   assign mem_req       = mem_phase_w && !timeout_w;
   assign mem_we        = (state_q == S_WB) && !timeout_w;
   assign mem_addr      = mem_req ? addr_q : '0;
   assign mem_wdata     = mem_we ? wb_data_q : '0;
   assign done          = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_bus_arbiter
// Desc     : Scoreboard bench for snoop_bus_arbiter (timeout case under ARB_MEM_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
module tb_snoop_bus_arbiter;

   localparam int NP = 4;
   localparam int K_BUS = 0, K_MEMW = 1, K_MEMR = 2, K_FILL = 3, K_DONE = 4, K_ERR = 5;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      logic        r;
      int          gap;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] req, req_rdwr, wrbk, shared_in;
   logic [NP*32-1:0] req_addr, wrbk_data;
   logic [31:0]   mem_rdata;
   logic          mem_ack;
   logic [NP-1:0] grant;
   logic          bus_valid, bus_rdwr, shared, ready_to_read, mem_req, mem_we, done, err;
   logic [1:0]    bus_proc_id;
   logic [31:0]   bus_addr, fill_data, mem_addr, mem_wdata;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  done_cnt = 0;
   int  mcyc = 0;
   int  last_evt = 0;
   int  last_ack = 0;

   logic        mem_en = 1'b1;
   int          mem_lat = 3;
   logic [31:0] rdata_val = '0;
   logic        spur_ack = 1'b0;
   logic        ack_pend = 1'b0;
   int          lat_cnt = 0;

   snoop_bus_arbiter #(
      .NUM_PROC(NP), .ID_W(2), .ADDR_W(32), .DATA_W(32), .MEM_TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_rdwr(req_rdwr), .req_addr(req_addr),
      .wrbk(wrbk), .wrbk_data(wrbk_data), .shared_in(shared_in),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant),
      .bus_valid(bus_valid), .bus_proc_id(bus_proc_id), .bus_addr(bus_addr),
      .bus_rdwr(bus_rdwr), .shared(shared), .ready_to_read(ready_to_read),
      .fill_data(fill_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, mcyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, mcyc);
   endtask

   function automatic void push(input int kind, input logic [31:0] a, input logic [31:0] b,
                                input logic r, input int gap);
      ev_t e;
      e.kind = kind; e.a = a; e.b = b; e.r = r; e.gap = gap;
      exp_q.push_back(e);
   endfunction

   task automatic pop_exp(input int kind, input string name, output bit ok, output ev_t e);
      ok = 1'b0;
      e.kind = -1; e.a = '0; e.b = '0; e.r = 1'b0; e.gap = -1;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: unexpected output with empty queue (cycle %0d)", name, mcyc);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_kind"}, kind, e.kind);
         ok = (e.kind == kind);
      end
   endtask

   task automatic gap_chk(input string name, input int gap);
      if (gap >= 0)
         chk(name, mcyc - last_evt, gap);
   endtask

   // Memory model: acks mem_lat cycles after a request is seen.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (ack_pend) begin
            ack_pend = 1'b0;
         end else if (mem_req && mem_en) begin
            if (lat_cnt >= mem_lat) begin
               ack_pend  = 1'b1;
               mem_rdata = rdata_val;
               lat_cnt   = 0;
            end else begin
               lat_cnt++;
            end
         end else begin
            lat_cnt = 0;
         end
         mem_ack = ack_pend | spur_ack;
      end
   end

   // Monitor: pops one expectation per observed output event.
   initial begin : monitor
      ev_t  e;
      bit   ok;
      logic prev_req  = 1'b0;
      logic prev_ack  = 1'b0;
      logic prev_done = 1'b0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (rst) begin
            prev_req = 1'b0; prev_ack = 1'b0; prev_done = 1'b0;
         end else begin
            if (prev_done)
               chk("grant_clear", 32'(grant), 32'd0);
            if (bus_valid) begin
               pop_exp(K_BUS, "bus", ok, e);
               if (ok) begin
                  chk("bus_proc_id", 32'(bus_proc_id), e.b);
                  chk("bus_addr", bus_addr, e.a);
                  chk("bus_rdwr", 32'(bus_rdwr), 32'(e.r));
                  chk("bus_grant", 32'(grant), 32'd1 << e.b);
                  gap_chk("bus_gap", e.gap);
               end
               last_evt = mcyc;
            end
            if (mem_req && (!prev_req || prev_ack)) begin
               pop_exp(mem_we ? K_MEMW : K_MEMR, "mem", ok, e);
               if (ok) begin
                  chk("mem_addr", mem_addr, e.a);
                  if (e.kind == K_MEMW)
                     chk("mem_wdata", mem_wdata, e.b);
                  gap_chk("mem_gap", e.gap);
               end
               last_evt = mcyc;
            end
            if (mem_ack && mem_req)
               last_ack = mcyc;
            if (ready_to_read) begin
               pop_exp(K_FILL, "fill", ok, e);
               if (ok) begin
                  chk("fill_data", fill_data, e.a);
                  chk("fill_lat", mcyc - last_ack, 32'd1);
               end
               last_evt = mcyc;
            end
            if (err) begin
               pop_exp(K_ERR, "err", ok, e);
               if (ok) begin
                  chk("err_mem_req", 32'(mem_req), 32'd0);
                  gap_chk("err_gap", e.gap);
               end
               last_evt = mcyc;
            end
            if (done) begin
               pop_exp(K_DONE, "done", ok, e);
               if (ok) begin
                  chk("done_shared", 32'(shared), e.b);
                  gap_chk("done_gap", e.gap);
               end
               done_cnt++;
               last_evt = mcyc;
            end
            prev_req  = mem_req;
            prev_ack  = mem_ack;
            prev_done = done;
         end
      end
   end

   task automatic set_core(input int i, input logic [31:0] addr, input logic rdwr);
      req_addr[i*32 +: 32] = addr;
      req_rdwr[i]          = rdwr;
   endtask

   task automatic wait_grant(input int id, input int budget);
      int k = 0;
      logic [1:0] gi;
      gi = id[1:0];
      while (grant[gi] !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (grant[gi] !== 1'b1)
         fail_now("grant_wait");
   endtask

   task automatic wait_dones(input int target, input int budget);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt < target)
         fail_now("done_wait");
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
      chk({tag, "_bus_proc_id"}, 32'(bus_proc_id), 32'd0);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_ctl"}, {26'd0, ready_to_read, done, err, shared, mem_we, bus_rdwr}, 32'd0);
      chk({tag, "_fill_data"}, fill_data, 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base;
      rst = 1'b1; req = '0; req_rdwr = '0; req_addr = '0;
      wrbk = '0; wrbk_data = '0; shared_in = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single read by core 2; owner's own wrbk/shared_in must be ignored.
      set_core(2, 32'h0000_1234, 1'b1);
      shared_in = 4'b0100; wrbk = 4'b0100; wrbk_data[2*32 +: 32] = 32'h77;
      rdata_val = 32'hDEAD_BEEF; mem_lat = 3;
      push(K_BUS, 32'h1234, 2, 1'b1, -1);
      push(K_MEMR, 32'h1234, 0, 1'b0, 1);
      push(K_FILL, 32'hDEAD_BEEF, 0, 1'b0, -1);
      push(K_DONE, 0, 0, 1'b0, 1);
      base = done_cnt;
      req[2] = 1'b1;
      wait_grant(2, 20);
      req[2] = 1'b0;
      wait_dones(base + 1, 40);
      shared_in = '0; wrbk = '0;
      @(negedge clk);

      // Core 0 read with a dirty copy in core 3.
      set_core(0, 32'h0000_0100, 1'b1);
      wrbk = 4'b1001; wrbk_data[3*32 +: 32] = 32'h55; wrbk_data[0 +: 32] = 32'hAA;
      shared_in = 4'b1000; rdata_val = 32'hCAFE_0001; mem_lat = 2;
      push(K_BUS, 32'h100, 0, 1'b1, -1);
      push(K_MEMW, 32'h100, 32'h55, 1'b0, 1);
      push(K_MEMR, 32'h100, 0, 1'b0, -1);
      push(K_FILL, 32'hCAFE_0001, 0, 1'b0, -1);
      push(K_DONE, 0, 1, 1'b0, 1);
      base = done_cnt;
      req[0] = 1'b1;
      wait_grant(0, 20);
      req[0] = 1'b0;
      wait_dones(base + 1, 60);
      wrbk = '0; shared_in = '0;
      @(negedge clk);

      // Core 1 write miss with stray mem_ack held high; no memory traffic.
      set_core(1, 32'h0000_0200, 1'b0);
      shared_in = 4'b1101; spur_ack = 1'b1;
      push(K_BUS, 32'h200, 1, 1'b0, -1);
      push(K_DONE, 0, 1, 1'b0, 1);
      base = done_cnt;
      req[1] = 1'b1;
      wait_grant(1, 20);
      req[1] = 1'b0;
      wait_dones(base + 1, 20);
      spur_ack = 1'b0; shared_in = '0;
      @(negedge clk);

      // Fairness from reset: all cores requesting writes.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NP; i++)
         set_core(i, 32'h1000 + 32'(i) * 32'h10, 1'b0);
      begin
         int order [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
         for (int n = 0; n < 9; n++) begin
            push(K_BUS, 32'h1000 + 32'(order[n]) * 32'h10, 32'(order[n]), 1'b0, (n == 0) ? -1 : 2);
            push(K_DONE, 0, 0, 1'b0, 1);
         end
      end
      base = done_cnt;
      req = 4'b1111;
      for (int n = 0; n < 9; n++) begin
         int k = 0;
         @(negedge clk);
         while (bus_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         if (bus_valid !== 1'b1)
            fail_now("fair_bus_wait");
         if (n == 4) begin
            req[0] = 1'b0;
            @(negedge clk);
            req[0] = 1'b1;
         end
         if (n == 8)
            req = '0;
      end
      wait_dones(base + 9, 20);
      @(negedge clk);

      // Reset while core 2 waits in MEM, then cores 0 and 3 contend.
      set_core(2, 32'h0000_0300, 1'b1);
      mem_en = 1'b0;
      push(K_BUS, 32'h300, 2, 1'b1, -1);
      push(K_MEMR, 32'h300, 0, 1'b0, 1);
      req[2] = 1'b1;
      wait_grant(2, 20);
      req[2] = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midreset");
      rst = 1'b0;
      mem_en = 1'b1; mem_lat = 1; rdata_val = 32'h0BAD_F00D;
      set_core(0, 32'h0000_0500, 1'b0);
      set_core(3, 32'h0000_0400, 1'b1);
      push(K_BUS, 32'h500, 0, 1'b0, -1);
      push(K_DONE, 0, 0, 1'b0, 1);
      push(K_BUS, 32'h400, 3, 1'b1, 2);
      push(K_MEMR, 32'h400, 0, 1'b0, 1);
      push(K_FILL, 32'h0BAD_F00D, 0, 1'b0, -1);
      push(K_DONE, 0, 0, 1'b0, 1);
      base = done_cnt;
      req = 4'b1001;
      wait_grant(0, 20);
      req[0] = 1'b0;
      wait_grant(3, 20);
      req[3] = 1'b0;
      wait_dones(base + 2, 60);
      @(negedge clk);

`ifdef ARB_MEM_TIMEOUT_EN
      // Memory never answers: err 8 cycles into MEM, no fill, done next.
      set_core(1, 32'h0000_0600, 1'b1);
      mem_en = 1'b0;
      push(K_BUS, 32'h600, 1, 1'b1, -1);
      push(K_MEMR, 32'h600, 0, 1'b0, 1);
      push(K_ERR, 0, 0, 1'b0, 8);
      push(K_DONE, 0, 0, 1'b0, 1);
      base = done_cnt;
      req[1] = 1'b1;
      wait_grant(1, 20);
      req[1] = 1'b0;
      wait_dones(base + 1, 40);
      chk("timeout_fill_data", fill_data, 32'd0);
      mem_en = 1'b1;
      @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
